// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_responder
// Description : Target end of an SRAM-like req/addr_ok/data_ok bus. Accepted
//               requests are queued in an in-order FIFO, issued one at a time
//               to a 1-cycle-latency block RAM, and answered with exactly one
//               data_ok pulse each, in acceptance order.
//               Optional macro SRAM_RESP_DELAY_EN inserts DELAY_CYCLES wait
//               cycles in front of every RAM issue.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_responder #(
   parameter int DEPTH        = 4,
   parameter int RAM_AW       = 14,
   parameter int DELAY_CYCLES = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   output logic              ram_en,
   output logic [3:0]        ram_wstrb,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_A_W   = RAM_AW + 2;   // byte-address bits actually kept

`ifdef SRAM_RESP_DELAY_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Counter holds the wait cycles still to go after the current one, so a
   // request spends exactly DELAY_CYCLES cycles in WAIT before issuing.
   localparam int c_DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [c_DW-1:0] c_DELAY_LOAD =
      c_DW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd1
   } state_t;
`endif

   // Request FIFO storage
   logic                 r_q_wr    [DEPTH];
   logic [1:0]           r_q_size  [DEPTH];
   logic [c_A_W-1:0]     r_q_addr  [DEPTH];
   logic [31:0]          r_q_wdata [DEPTH];
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_PTR_W:0]     r_count;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_issue;
   logic                 w_push;
   logic                 w_full;
   logic                 w_empty;
   logic [3:0]           w_strb;

   logic                 w_head_wr;
   logic [1:0]           w_head_size;
   logic [c_A_W-1:0]     w_head_addr;
   logic [31:0]          w_head_wdata;

`ifdef SRAM_RESP_DELAY_EN
   logic [c_DW-1:0]      r_delay;
   logic [c_DW-1:0]      w_delay_nxt;
`endif

   // Upper address bits fall outside the RAM and are intentionally dropped.
   logic w_unused;
   assign w_unused = &{1'b0, addr[31:c_A_W]};

   // Fullness comes only from the registered count, so a same-cycle pop never
   // opens a slot and addr_ok has no path from the response side.
   assign w_full  = (r_count == (c_PTR_W+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign addr_ok = req & ~w_full;
   assign w_push  = req & ~w_full;

   assign w_head_wr    = r_q_wr[r_rptr];
   assign w_head_size  = r_q_size[r_rptr];
   assign w_head_addr  = r_q_addr[r_rptr];
   assign w_head_wdata = r_q_wdata[r_rptr];

   // FIFO payload write; storage needs no reset since count guards reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_wr[r_wptr]    <= wr;
         r_q_size[r_wptr]  <= size;
         r_q_addr[r_wptr]  <= addr[c_A_W-1:0];
         r_q_wdata[r_wptr] <= wdata;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_issue) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Byte-lane enables for the head request; illegal shapes write nothing.
   always_comb begin
      w_strb = 4'b0000;
      if (w_head_wr) begin
         case (w_head_size)
            2'd0: w_strb = 4'b0001 << w_head_addr[1:0];
            2'd1: if (!w_head_addr[0]) w_strb = 4'b0011 << w_head_addr[1:0];
            2'd2: if (w_head_addr[1:0] == 2'b00) w_strb = 4'b1111;
            default: w_strb = 4'b0000;
         endcase
      end
   end

   // FSM state register (and wait counter when delays are enabled).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
`ifdef SRAM_RESP_DELAY_EN
         r_delay <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
`ifdef SRAM_RESP_DELAY_EN
         r_delay <= w_delay_nxt;
`endif
      end
   end

   // FSM next state and RAM issue decision.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
`ifdef SRAM_RESP_DELAY_EN
      w_delay_nxt = r_delay;
`endif
      case (r_state)
         S_IDLE, S_RESP: begin
            if (!w_empty) begin
`ifdef SRAM_RESP_DELAY_EN
               if (DELAY_CYCLES == 0) begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_delay_nxt = c_DELAY_LOAD;
               end
`else
               w_issue     = 1'b1;
               w_state_nxt = S_RESP;
`endif
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef SRAM_RESP_DELAY_EN
         // Nothing pops while waiting, so the FIFO is still non-empty here.
         S_WAIT: begin
            if (r_delay == '0) begin
               w_issue     = 1'b1;
               w_state_nxt = S_RESP;
            end else begin
               w_delay_nxt = r_delay - c_DW'(1);
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // RAM side is quiet (all zero) whenever nothing is being issued.
   assign ram_en    = w_issue;
   assign ram_wstrb = w_issue ? w_strb : 4'b0000;
   assign ram_addr  = w_issue ? w_head_addr[c_A_W-1:2] : '0;
   assign ram_wdata = w_issue ? w_head_wdata : '0;

   // Response: RESP lasts one cycle per issued request; RAM data passes through.
   assign data_ok = (r_state == S_RESP);
   assign rdata   = data_ok ? ram_rdata : 32'h0;

endmodule
`default_nettype wire
